// File: rtl/data_memory_responder.sv
// data_memory_responder: word-array responder for the 16-bit CPU memory buses
// Data port: registered 1-cycle access with ready pulse; fetch port: combinational read
module data_memory_responder #(
    parameter int ADDR_W      = 12,
    parameter int DATA_W      = 16,
    parameter int DEPTH_WORDS = 2048
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] Instruction_addressbus,
    output logic [DATA_W-1:0] Instruction_databus,
    input  logic [ADDR_W-1:0] Memory_addressbus,
    inout  wire  [DATA_W-1:0] Memory_databus,
    input  logic              Memory_writemode,
    input  logic              Memory_request,
    output logic              Memory_ready,
    output logic              Memory_misaligned,
    output logic              Memory_bus_conflict
);

    localparam int IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [ADDR_W-1:0] DEPTH_L = ADDR_W'(DEPTH_WORDS);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ACK   = 2'd1;
    localparam logic [1:0] ST_DRIVE = 2'd2;

    logic [DATA_W-1:0] mem_q [DEPTH_WORDS];

    logic [1:0]        state_q, state_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              mis_q, mis_d;
    logic              conflict_q, conflict_d;
    logic              mem_we;

    logic [ADDR_W-2:0] i_idx;
    logic [ADDR_W-2:0] m_idx;
    logic              i_in_range;
    logic              m_in_range;
    logic              drive_en;
    logic              unused_fetch_lsb;

    assign i_idx      = Instruction_addressbus[ADDR_W-1:1];
    assign m_idx      = Memory_addressbus[ADDR_W-1:1];
    assign i_in_range = ({1'b0, i_idx} < DEPTH_L);
    assign m_in_range = ({1'b0, m_idx} < DEPTH_L);

    // Byte offset is irrelevant to a word fetch
    assign unused_fetch_lsb = Instruction_addressbus[0];

    // Fetch port reads the array directly; holes above the array read as zero
    assign Instruction_databus = i_in_range ? mem_q[i_idx[IDX_W-1:0]] : '0;

    // Next-state and capture logic for the data port
    always_comb begin
        state_d    = state_q;
        rdata_d    = rdata_q;
        mis_d      = mis_q;
        conflict_d = conflict_q;
        mem_we     = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (Memory_request) begin
                    mis_d = Memory_addressbus[0];
                    if (Memory_writemode) begin
                        mem_we  = m_in_range & ~rst;
                        state_d = ST_ACK;
                    end else begin
                        rdata_d = m_in_range ? mem_q[m_idx[IDX_W-1:0]] : '0;
                        state_d = ST_DRIVE;
                    end
                end
            end
            ST_ACK: begin
                state_d = ST_IDLE;
            end
            ST_DRIVE: begin
                if (Memory_writemode) begin
                    conflict_d = 1'b1;
                end
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Control and read-data registers; reset aborts any pending ack/drive
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            rdata_q    <= '0;
            mis_q      <= 1'b0;
            conflict_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            rdata_q    <= rdata_d;
            mis_q      <= mis_d;
            conflict_q <= conflict_d;
        end
    end

    // Data-port write into the array; contents survive reset
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[m_idx[IDX_W-1:0]] <= Memory_databus;
        end
    end

    // Requester driving a write during our drive slot wins: we back off
    assign drive_en = (state_q == ST_DRIVE) & ~Memory_writemode;

    assign Memory_databus      = drive_en ? rdata_q : 'z;
    assign Memory_ready        = (state_q != ST_IDLE);
    assign Memory_misaligned   = Memory_ready & mis_q;
    assign Memory_bus_conflict = conflict_q
                               | ((state_q == ST_DRIVE) & Memory_writemode);

endmodule

// File: tb/tb_data_memory_responder.sv
// tb_data_memory_responder: directed + random checks of two responder instances
// (full 2048-word array and a 16-word array) against an array/queue-level model
module tb_data_memory_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic [11:0] i_addr;
    logic [11:0] m_addr;
    logic        wm;
    logic        req;
    logic [15:0] tb_wdata;
    wire         tb_drive;
    wire  [15:0] bus_a;
    wire  [15:0] bus_b;
    logic [15:0] ins_a, ins_b;
    logic        rdy_a, rdy_b, mis_a, mis_b, cf_a, cf_b;

    int n_chk  = 0;
    int n_fail = 0;
    bit run_cmp = 1'b0;

    assign tb_drive = req & wm;
    assign bus_a = tb_drive ? tb_wdata : 16'hzzzz;
    assign bus_b = tb_drive ? tb_wdata : 16'hzzzz;

    always #5 clk = ~clk;

    data_memory_responder #(.ADDR_W(12), .DATA_W(16), .DEPTH_WORDS(2048)) dut_a (
        .clk                    (clk),
        .rst                    (rst),
        .Instruction_addressbus (i_addr),
        .Instruction_databus    (ins_a),
        .Memory_addressbus      (m_addr),
        .Memory_databus         (bus_a),
        .Memory_writemode       (wm),
        .Memory_request         (req),
        .Memory_ready           (rdy_a),
        .Memory_misaligned      (mis_a),
        .Memory_bus_conflict    (cf_a)
    );

    data_memory_responder #(.ADDR_W(12), .DATA_W(16), .DEPTH_WORDS(16)) dut_b (
        .clk                    (clk),
        .rst                    (rst),
        .Instruction_addressbus (i_addr),
        .Instruction_databus    (ins_b),
        .Memory_addressbus      (m_addr),
        .Memory_databus         (bus_b),
        .Memory_writemode       (wm),
        .Memory_request         (req),
        .Memory_ready           (rdy_b),
        .Memory_misaligned      (mis_b),
        .Memory_bus_conflict    (cf_b)
    );

    // Behavioural model: word arrays with known-flags, one pending-access record
    logic [15:0] ma [2048];
    bit          ka [2048];
    logic [15:0] mb [16];
    bit          kb [16];
    bit          busy  = 1'b0;
    bit          is_rd = 1'b0;
    bit          mis_m = 1'b0;
    bit          cf_m  = 1'b0;
    logic [15:0] rd_a  = '0;
    logic [15:0] rd_b  = '0;
    bit          rd_a_k = 1'b0;
    bit          rd_b_k = 1'b0;

    always @(posedge clk or posedge rst) begin : model
        int ia;
        if (rst) begin
            busy = 1'b0;
            cf_m = 1'b0;
        end else if (busy) begin
            if (is_rd && wm) cf_m = 1'b1;
            busy = 1'b0;
        end else if (req) begin
            ia    = int'(m_addr[11:1]);
            busy  = 1'b1;
            is_rd = !wm;
            mis_m = m_addr[0];
            if (wm) begin
                ma[ia] = tb_wdata;
                ka[ia] = 1'b1;
                if (ia < 16) begin
                    mb[ia] = tb_wdata;
                    kb[ia] = 1'b1;
                end
            end else begin
                rd_a   = ma[ia];
                rd_a_k = ka[ia];
                if (ia < 16) begin
                    rd_b   = mb[ia];
                    rd_b_k = kb[ia];
                end else begin
                    rd_b   = 16'h0000;
                    rd_b_k = 1'b1;
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
        end
    endtask

    task automatic chk1(input string nm, input logic act, input logic exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %b expected %b", nm, $time, act, exp);
        end
    endtask

    // Per-cycle compare of both instances against the model
    initial begin : compare
        bit drv, a_z, b_z, exp_cf;
        int ii;
        forever begin
            @(negedge clk);
            #2;
            if (run_cmp) begin
                drv    = busy && is_rd && !wm;
                exp_cf = cf_m | (busy & is_rd & wm);
                a_z    = (bus_a === 16'hzzzz);
                b_z    = (bus_b === 16'hzzzz);
                chk1("bus_a_released", a_z, !(drv || tb_drive));
                chk1("bus_b_released", b_z, !(drv || tb_drive));
                if (drv && rd_a_k) chk("bus_a_data", bus_a, rd_a);
                if (drv && rd_b_k) chk("bus_b_data", bus_b, rd_b);
                chk1("ready_a", rdy_a, busy);
                chk1("ready_b", rdy_b, busy);
                chk1("misaligned_a", mis_a, busy & mis_m);
                chk1("misaligned_b", mis_b, busy & mis_m);
                chk1("conflict_a", cf_a, exp_cf);
                chk1("conflict_b", cf_b, exp_cf);
                ii = int'(i_addr[11:1]);
                if (ka[ii]) chk("fetch_a", ins_a, ma[ii]);
                if (ii >= 16) chk("fetch_b", ins_b, 16'h0000);
                else if (kb[ii]) chk("fetch_b", ins_b, mb[ii]);
            end
        end
    end

    // One access presented for a single edge; returns in the ack/drive cycle
    task automatic acc(input logic [11:0] a, input logic w, input logic [15:0] d);
        @(negedge clk);
        m_addr   = a;
        wm       = w;
        req      = 1'b1;
        tb_wdata = d;
        @(negedge clk);
        req = 1'b0;
        wm  = 1'b0;
    endtask

    initial begin : stim
        bit z;
        rst = 1'b1; req = 1'b0; wm = 1'b0;
        m_addr = '0; i_addr = '0; tb_wdata = '0;
        repeat (2) @(negedge clk);
        #1;
        z = (bus_a === 16'hzzzz);
        chk1("reset_bus_z", z, 1'b1);
        chk1("reset_ready", rdy_a, 1'b0);
        chk1("reset_conflict", cf_a, 1'b0);
        rst = 1'b0;
        run_cmp = 1'b1;

        // write then read back, then release
        acc(12'h010, 1'b1, 16'hBEEF); #3;
        chk1("wr_ready", rdy_a, 1'b1);
        acc(12'h010, 1'b0, 16'h0000); #3;
        chk1("rd_ready", rdy_a, 1'b1);
        chk("rd_data", bus_a, 16'hBEEF);
        @(negedge clk); #3;
        z = (bus_a === 16'hzzzz);
        chk1("rd_release_z", z, 1'b1);
        chk1("rd_release_ready", rdy_a, 1'b0);

        // fetch port and same-cycle write ordering
        i_addr = 12'h010; #1;
        chk("fetch_beef", ins_a, 16'hBEEF);
        @(negedge clk);
        m_addr = 12'h010; wm = 1'b1; req = 1'b1; tb_wdata = 16'h1234; #3;
        chk("fetch_old", ins_a, 16'hBEEF);
        @(negedge clk);
        req = 1'b0; wm = 1'b0; #3;
        chk("fetch_new", ins_a, 16'h1234);

        // misaligned write, aligned read of the same word
        acc(12'h013, 1'b1, 16'hA5A5); #3;
        chk1("mis_wr_ready", rdy_a, 1'b1);
        chk1("mis_wr_flag", mis_a, 1'b1);
        acc(12'h012, 1'b0, 16'h0000); #3;
        chk("mis_rd_data", bus_a, 16'hA5A5);
        chk1("mis_rd_flag", mis_a, 1'b0);

        // beyond the 16-word array
        acc(12'h000, 1'b1, 16'h5A5A);
        acc(12'h040, 1'b1, 16'h7777); #3;
        chk1("oob_wr_ready", rdy_b, 1'b1);
        acc(12'h040, 1'b0, 16'h0000); #3;
        chk("oob_rd_b", bus_b, 16'h0000);
        chk("oob_rd_a", bus_a, 16'h7777);
        acc(12'h000, 1'b0, 16'h0000); #3;
        chk("word0_b", bus_b, 16'h5A5A);

        // writemode raised during the drive slot
        @(negedge clk);
        m_addr = 12'h012; wm = 1'b0; req = 1'b1;
        @(negedge clk);
        req = 1'b0; wm = 1'b1; #3;
        z = (bus_a === 16'hzzzz);
        chk1("conf_bus_z", z, 1'b1);
        chk1("conf_ready", rdy_a, 1'b1);
        chk1("conf_flag", cf_a, 1'b1);
        @(negedge clk);
        wm = 1'b0; #3;
        chk1("conf_sticky", cf_a, 1'b1);

        // reset during drive
        acc(12'h010, 1'b0, 16'h0000);
        rst = 1'b1; #1;
        z = (bus_a === 16'hzzzz);
        chk1("rst_drive_z", z, 1'b1);
        chk1("rst_drive_ready", rdy_a, 1'b0);
        chk1("rst_conflict_clr", cf_a, 1'b0);
        @(negedge clk);
        rst = 1'b0; #3;
        chk1("rst_no_ready", rdy_a, 1'b0);
        acc(12'h010, 1'b0, 16'h0000); #3;
        chk("post_rst_rd", bus_a, 16'h1234);

        // random traffic, biased toward the small array
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            rst = (!rst && $urandom_range(0, 99) == 0);
            req = 1'($urandom_range(0, 1));
            wm  = 1'($urandom_range(0, 1));
            m_addr = ($urandom_range(0, 1) == 1) ? 12'($urandom_range(0, 63))
                                                 : 12'($urandom);
            i_addr = ($urandom_range(0, 1) == 1) ? 12'($urandom_range(0, 63))
                                                 : 12'($urandom);
            tb_wdata = 16'($urandom);
        end

        @(negedge clk);
        rst = 1'b0; req = 1'b0; wm = 1'b0;
        repeat (3) @(negedge clk);
        #4;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
